// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields and an extended immediate back into
// a 32-bit instruction word. Illegal formats, misaligned immediates and
// out-of-range immediates are rejected. Legal words pass through a one-entry
// valid/ready output register and receive an auto-incrementing write address.
module instr_encoder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // upstream field interface
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [6:0]            opcode_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [2:0]            ImmSrc_i,
    // downstream instruction-memory write interface
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    // status
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [15:0]           count_o
);

    // Immediate format selectors, matching the immediate extender encoding.
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;
    localparam logic [2:0] SRC_R = 3'b101;

    // Rejection reasons; ERR_NONE marks a legal input.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             count_q, count_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;

    logic [DATA_WIDTH-1:0]   packed_w;
    logic [1:0]              check_code_w;
    logic                    accept_w;
    logic                    handoff_w;
    logic                    load_w;
    logic                    reject_w;

    // An immediate fits N bits signed when bits [31:N-1] are all copies of the sign.
    logic fits_12_w;
    logic fits_13_w;
    logic fits_21_w;

    assign fits_12_w = (imm_i[31:11] == '0) || (&imm_i[31:11]);
    assign fits_13_w = (imm_i[31:12] == '0) || (&imm_i[31:12]);
    assign fits_21_w = (imm_i[31:20] == '0) || (&imm_i[31:20]);

    // Handshakes. ready_o is forced high in reset so the loader never sees a stall there.
    assign ready_o   = rst_i || (state_q == ST_EMPTY) || ready_i;
    assign accept_w  = valid_i && ready_o;
    assign handoff_w = (state_q == ST_FULL) && ready_i;
    assign load_w    = accept_w && (check_code_w == ERR_NONE);
    assign reject_w  = accept_w && (check_code_w != ERR_NONE);

    // Scatter the immediate into the instruction bit positions for each format.
    always_comb begin
        packed_w = '0;
        case (ImmSrc_i)
            SRC_I: packed_w = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            SRC_S: packed_w = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            SRC_B: packed_w = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
            SRC_U: packed_w = {imm_i[31:12], rd_i, opcode_i};
            SRC_J: packed_w = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, opcode_i};
            SRC_R: packed_w = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            default: packed_w = '0;
        endcase
    end

    // Legality check: illegal format beats alignment, alignment beats range.
    // Anything that would not round-trip through the extender is rejected.
    always_comb begin
        check_code_w = ERR_NONE;
        case (ImmSrc_i)
            SRC_I, SRC_S: begin
                if (!fits_12_w) check_code_w = ERR_RANGE;
            end
            SRC_B: begin
                if (imm_i[0])        check_code_w = ERR_ALIGN;
                else if (!fits_13_w) check_code_w = ERR_RANGE;
            end
            SRC_U: begin
                if (imm_i[11:0] != 12'h000) check_code_w = ERR_ALIGN;
            end
            SRC_J: begin
                if (imm_i[0])        check_code_w = ERR_ALIGN;
                else if (!fits_21_w) check_code_w = ERR_RANGE;
            end
            SRC_R: check_code_w = ERR_NONE;
            default: check_code_w = ERR_ILLEGAL;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: a fresh legal load always wins; otherwise a handoff empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (load_w) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (load_w)         state_d = ST_FULL;
                else if (handoff_w) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Datapath next-state: instruction, address, handoff count and error pulse.
    always_comb begin
        instr_d    = instr_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = reject_w;
        err_code_d = reject_w ? check_code_w : ERR_NONE;
        if (load_w) begin
            instr_d = packed_w;
        end
        // The address tracks the word being handed off, so it moves only on handoff.
        if (handoff_w) begin
            addr_d = addr_q + ADDR_WIDTH'(4);
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // Datapath registers; reset drops any held word and rewinds the address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q    <= '0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign valid_o    = (state_q == ST_FULL);
    assign instr_o    = instr_q;
    assign addr_o     = addr_q;
    assign count_o    = count_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes the hand-computed
// expected word/address (or error code) into queues; a monitor pops and
// compares on every downstream handoff and every error pulse.
module tb_instr_encoder;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic [2:0]  ImmSrc_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        valid_o;
    logic        ready_i;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [15:0] count_o;

    // Second instance for address wrap-around (4-bit address, base 12).
    logic        w_rst, w_valid_i, w_ready_o, w_ready_i, w_valid_o, w_err_o;
    logic [31:0] w_instr_o;
    logic [3:0]  w_addr_o;
    logic [1:0]  w_err_code_o;
    logic [15:0] w_count_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];   // {instr, addr}
    logic [1:0]  err_q[$];

    instr_encoder u_dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .ImmSrc_i(ImmSrc_i),
        .instr_o(instr_o), .addr_o(addr_o), .valid_o(valid_o), .ready_i(ready_i),
        .err_o(err_o), .err_code_o(err_code_o), .count_o(count_o)
    );

    instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(4'd12)) u_wrap (
        .clk_i(clk), .rst_i(w_rst), .valid_i(w_valid_i), .ready_o(w_ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i), .ImmSrc_i(ImmSrc_i),
        .instr_o(w_instr_o), .addr_o(w_addr_o), .valid_o(w_valid_o), .ready_i(w_ready_i),
        .err_o(w_err_o), .err_code_o(w_err_code_o), .count_o(w_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: samples mid-low-phase, after stimulus settles and before the next edge.
    always @(negedge clk) begin
        #2;
        if (!rst_i) begin
            if (valid_o && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL handoff: unexpected instr 0x%08h @0x%08h", instr_o, addr_o);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({instr_o, addr_o} !== e) begin
                        errors++;
                        $display("FAIL handoff: got 0x%08h @0x%08h expected 0x%08h @0x%08h",
                                 instr_o, addr_o, e[63:32], e[31:0]);
                    end else begin
                        $display("ok   handoff: 0x%08h @0x%08h", instr_o, addr_o);
                    end
                end
            end
            if (err_o) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_pulse: unexpected err_code %0d", err_code_o);
                end else begin
                    logic [1:0] ec;
                    ec = err_q.pop_front();
                    if (err_code_o !== ec) begin
                        errors++;
                        $display("FAIL err_code: got %0d expected %0d", err_code_o, ec);
                    end else begin
                        $display("ok   err_code: %0d", err_code_o);
                    end
                end
            end
        end
    end

    // Present one input at a negedge and wait (bounded) until it is accepted.
    task automatic put(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
        int n;
        @(negedge clk);
        ImmSrc_i = src; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm; valid_i = 1'b1;
        #1;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready_o stayed 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
    endtask

    task automatic send_ok(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [31:0] imm, input logic [31:0] e_instr,
                           input logic [31:0] e_addr);
        exp_q.push_back({e_instr, e_addr});
        put(src, op, rd, rs1, rs2, f3, 7'd0, imm);
    endtask

    task automatic send_bad(input logic [2:0] src, input logic [6:0] op, input logic [31:0] imm,
                            input logic [1:0] code);
        err_q.push_back(code);
        put(src, op, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        err_q.delete();
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0;
        imm_i = '0; ImmSrc_i = '0;
        w_rst = 1'b1; w_valid_i = 1'b0; w_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("ready_in_reset", {31'd0, ready_o}, 32'd1);
        rst_i = 1'b0; w_rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_count", {16'd0, count_o}, 32'd0);
        chk("rst_err", {29'd0, err_o, err_code_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);

        // I type, one word
        send_ok(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFF,
                32'hFFF0_0093, 32'd0);
        @(negedge clk);
        #1;
        chk("i_valid_next", {31'd0, valid_o}, 32'd1);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("i_count", {16'd0, count_o}, 32'd1);
        chk("i_addr_after", addr_o, 32'd4);

        // Back-to-back S, B, J
        do_reset();
        send_ok(3'b001, 7'b0100011, 5'd0, 5'd0, 5'd2, 3'b010, 32'd8, 32'h0020_2423, 32'd0);
        send_ok(3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFC,
                32'hFE00_0EE3, 32'd4);
        send_ok(3'b100, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'd8, 32'h0080_00EF, 32'd8);
        idle(3);
        chk("sbj_count", {16'd0, count_o}, 32'd3);
        chk("sbj_valid_clear", {31'd0, valid_o}, 32'd0);

        // Illegal inputs, each consumed
        do_reset();
        send_bad(3'b000, 7'b0010011, 32'd2048, 2'b01);
        send_bad(3'b010, 7'b1100011, 32'd5, 2'b10);
        send_bad(3'b011, 7'b0110111, 32'h1234_5001, 2'b10);
        send_bad(3'b110, 7'b0010011, 32'd0, 2'b11);
        idle(2);
        chk("bad_valid", {31'd0, valid_o}, 32'd0);
        chk("bad_addr", addr_o, 32'd0);
        chk("bad_count", {16'd0, count_o}, 32'd0);
        chk("bad_err_drained", err_q.size(), 32'd0);
        chk("bad_err_low", {31'd0, err_o}, 32'd0);

        // Backpressure while FULL
        do_reset();
        ready_i = 1'b0;
        send_ok(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'hFFFF_FFFF,
                32'hFFF0_0093, 32'd0);
        exp_q.push_back({32'h0020_2423, 32'd4});
        @(negedge clk);
        ImmSrc_i = 3'b001; opcode_i = 7'b0100011; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd2;
        funct3_i = 3'b010; imm_i = 32'd8; valid_i = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
            chk("bp_instr_hold", instr_o, 32'hFFF0_0093);
            chk("bp_addr_hold", addr_o, 32'd0);
            @(negedge clk);
            #1;
        end
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("bp_reload_instr", instr_o, 32'h0020_2423);
        chk("bp_reload_addr", addr_o, 32'd4);
        chk("bp_reload_valid", {31'd0, valid_o}, 32'd1);
        repeat (2) @(negedge clk);
        chk("bp_count", {16'd0, count_o}, 32'd2);

        // Reset while FULL with ready_i low: the held word is discarded
        @(negedge clk);
        ready_i = 1'b0;
        put(3'b100, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("mid_full", {31'd0, valid_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_addr", addr_o, 32'd0);
        chk("mid_rst_count", {16'd0, count_o}, 32'd0);
        exp_q.delete();
        rst_i = 1'b0;
        ready_i = 1'b1;

        // Address wrap on the 4-bit instance
        @(negedge clk);
        ImmSrc_i = 3'b000; opcode_i = 7'b0010011; rd_i = 5'd1; rs1_i = 5'd0; rs2_i = 5'd0;
        funct3_i = 3'b000; imm_i = 32'd1;
        #1;
        chk("wrap_base", {28'd0, w_addr_o}, 32'd12);
        w_valid_i = 1'b1;
        @(negedge clk);
        #1;
        chk("wrap_first", {28'd0, w_addr_o}, 32'd12);
        chk("wrap_first_valid", {31'd0, w_valid_o}, 32'd1);
        @(negedge clk);
        w_valid_i = 1'b0;
        #1;
        chk("wrap_second", {28'd0, w_addr_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("wrap_third", {28'd0, w_addr_o}, 32'd4);
        chk("wrap_count", {16'd0, w_count_o}, 32'd2);

        idle(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
